// File: rtl/flatten_stream_pkg.sv
// Shared types for the tensor flattener: element type and run-state encoding.
package flatten_stream_pkg;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } flatten_state_t;

endpackage

// File: rtl/flatten_stream_pingpong_buf.sv
// Two chunk-wide buffers with full flags and write/read pointers; the read side
// presents one OUT_LANES-wide slice of the read buffer selected by the beat offset.
module flatten_stream_pingpong_buf
  import flatten_stream_pkg::*;
#(
  parameter int ELEM_BITS   = 8,
  parameter int CHUNK_ELEMS = 16,
  parameter int OUT_LANES   = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic                                    wr_en,
  input  logic [CHUNK_ELEMS*ELEM_BITS-1:0]        wr_data,
  input  logic                                    rd_release,
  input  logic [$clog2(CHUNK_ELEMS/OUT_LANES)-1:0] beat,
  output logic                                    wr_full,
  output logic                                    rd_full,
  output logic [OUT_LANES*ELEM_BITS-1:0]          rd_data
);

  localparam int CHUNK_BITS = CHUNK_ELEMS * ELEM_BITS;
  localparam int LANE_BITS  = OUT_LANES * ELEM_BITS;
  localparam int BEATS      = CHUNK_ELEMS / OUT_LANES;
  localparam int BEAT_W     = $clog2(BEATS);

  logic [CHUNK_BITS-1:0] mem_q [2];
  logic [1:0]            full_q;
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Writer only targets an empty buffer and reader only frees a full one,
  // so a write and a release in the same cycle never touch the same entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      full_q <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      full_q <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr]  <= wr_data;
        full_q[wr_ptr] <= 1'b1;
        wr_ptr         <= ~wr_ptr;
      end
      if (rd_release) begin
        full_q[rd_ptr] <= 1'b0;
        rd_ptr         <= ~rd_ptr;
      end
    end
  end

  assign wr_full = full_q[wr_ptr];
  assign rd_full = full_q[rd_ptr];

  always_comb begin
    rd_data = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) rd_data = mem_q[rd_ptr][b*LANE_BITS +: LANE_BITS];
    end
  end

endmodule

// File: rtl/flatten_stream.sv
// Streams an HxWxC tensor, fetched chunk by chunk into ping-pong buffers, out as
// OUT_LANES-element valid/ready beats in HWC order.
module flatten_stream
  import flatten_stream_pkg::*;
#(
  parameter int INPUT_HEIGHT   = 2,
  parameter int INPUT_WIDTH    = 2,
  parameter int INPUT_CHANNELS = 64,
  parameter int ELEM_BITS      = 8,
  parameter int CHUNK_ELEMS    = 16,
  parameter int OUT_LANES      = 4,
  parameter int ADDR_W         = 10
) (
  input  logic                                                       clk,
  input  logic                                                       reset,
  input  logic                                                       start_flatten,
  input  logic                                                       flatten_abort,
  input  logic [ADDR_W-1:0]                                          base_chunk_addr,
  output logic                                                       request_chunk,
  output logic [ADDR_W-1:0]                                          chunk_addr,
  input  logic [CHUNK_ELEMS*ELEM_BITS-1:0]                           input_chunk,
  input  logic                                                       chunk_valid,
  output logic                                                       out_valid,
  input  logic                                                       out_ready,
  output logic [OUT_LANES*ELEM_BITS-1:0]                             out_data,
  output logic [$clog2(INPUT_HEIGHT*INPUT_WIDTH*INPUT_CHANNELS)-1:0] out_addr,
  output logic                                                       out_last,
  output logic                                                       busy,
  output logic                                                       flatten_complete
);

  localparam int OUTPUT_SIZE  = INPUT_HEIGHT * INPUT_WIDTH * INPUT_CHANNELS;
  localparam int TOTAL_CHUNKS = OUTPUT_SIZE / CHUNK_ELEMS;
  localparam int BEATS        = CHUNK_ELEMS / OUT_LANES;
  localparam int OUT_ADDR_W   = $clog2(OUTPUT_SIZE);
  localparam int FETCH_W      = $clog2(TOTAL_CHUNKS + 1);
  localparam int BEAT_W       = $clog2(BEATS);
  localparam logic [OUT_ADDR_W-1:0] LAST_ADDR = OUT_ADDR_W'(OUTPUT_SIZE - OUT_LANES);

  if (OUTPUT_SIZE % CHUNK_ELEMS != 0) begin : g_bad_chunking
    $error("flatten_stream: OUTPUT_SIZE must be a multiple of CHUNK_ELEMS");
  end
  if ((CHUNK_ELEMS % OUT_LANES != 0) || (CHUNK_ELEMS / OUT_LANES < 2)) begin : g_bad_lanes
    $error("flatten_stream: CHUNK_ELEMS must be a multiple of OUT_LANES with at least 2 beats");
  end

  flatten_state_t          state_q;
  logic [FETCH_W-1:0]      fetch_q;
  logic [ADDR_W-1:0]       base_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [OUT_ADDR_W-1:0]   addr_q;
  logic                    run;
  logic                    xfer;
  logic                    accept;
  logic                    chunk_end;
  logic                    flush;
  logic                    wr_full;
  logic                    rd_full;

  // Abort outranks every other event in its cycle, including a chunk arrival.
  assign run       = (state_q == RUN);
  assign xfer      = run & request_chunk & chunk_valid & ~flatten_abort;
  assign accept    = out_valid & out_ready & ~flatten_abort;
  assign chunk_end = accept & (beat_q == BEAT_W'(BEATS - 1));
  assign flush     = flatten_abort | (start_flatten & ~run);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      request_chunk <= 1'b0;
      fetch_q       <= '0;
      base_q        <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
    end else if (flatten_abort) begin
      state_q       <= IDLE;
      request_chunk <= 1'b0;
      fetch_q       <= '0;
      beat_q        <= '0;
      addr_q        <= '0;
    end else if (!run) begin
      if (start_flatten) begin
        state_q       <= RUN;
        base_q        <= base_chunk_addr;
        request_chunk <= 1'b1;
        fetch_q       <= '0;
        beat_q        <= '0;
        addr_q        <= '0;
      end
    end else begin
      // One request outstanding at most; drop for a cycle after each transfer.
      if (xfer) begin
        fetch_q       <= fetch_q + FETCH_W'(1);
        request_chunk <= 1'b0;
      end else if (!request_chunk && (fetch_q < FETCH_W'(TOTAL_CHUNKS)) && !wr_full) begin
        request_chunk <= 1'b1;
      end
      if (accept) begin
        addr_q <= addr_q + OUT_ADDR_W'(OUT_LANES);
        beat_q <= chunk_end ? '0 : beat_q + BEAT_W'(1);
        if (addr_q == LAST_ADDR) state_q <= DONE;
      end
    end
  end

  flatten_stream_pingpong_buf #(
    .ELEM_BITS   (ELEM_BITS),
    .CHUNK_ELEMS (CHUNK_ELEMS),
    .OUT_LANES   (OUT_LANES)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .wr_en      (xfer),
    .wr_data    (input_chunk),
    .rd_release (chunk_end),
    .beat       (beat_q),
    .wr_full    (wr_full),
    .rd_full    (rd_full),
    .rd_data    (out_data)
  );

  assign chunk_addr       = base_q + ADDR_W'(fetch_q);
  assign out_valid        = run & rd_full;
  assign out_addr         = addr_q;
  assign out_last         = out_valid & (addr_q == LAST_ADDR);
  assign busy             = run;
  assign flatten_complete = (state_q == DONE);

endmodule

// File: tb/tb_flatten_stream.sv
// Bench for flatten_stream: element-index memory model, per-cycle scoreboard on the
// default instance, and a second 3x3x8 single-lane instance.
module tb_flatten_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- default instance ----------------
  logic         start = 1'b0, abort = 1'b0, out_ready = 1'b0, cv_force = 1'b0;
  logic [9:0]   base_in = '0, tb_base = '0, rel;
  logic         request_chunk, chunk_valid, out_valid, out_last, busy, flatten_complete;
  logic [9:0]   chunk_addr;
  logic [127:0] input_chunk;
  logic [31:0]  out_data;
  logic [7:0]   out_addr;
  int           mem_lat = 0, age = 0;

  flatten_stream dut (
    .clk(clk), .reset(reset), .start_flatten(start), .flatten_abort(abort),
    .base_chunk_addr(base_in), .request_chunk(request_chunk), .chunk_addr(chunk_addr),
    .input_chunk(input_chunk), .chunk_valid(chunk_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .flatten_complete(flatten_complete)
  );

  // Memory: answers a request mem_lat cycles after it is raised; element e holds e mod 256.
  always @(posedge clk) age <= (request_chunk && !chunk_valid) ? age + 1 : 0;
  assign chunk_valid = cv_force | (request_chunk && (age >= mem_lat));
  always_comb begin
    rel = chunk_addr - tb_base;
    input_chunk = '0;
    for (int i = 0; i < 16; i++) input_chunk[i*8 +: 8] = 8'(int'(rel) * 16 + i);
  end

  function automatic logic [31:0] beat_model(input int a);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = 8'(a + k);
    return r;
  endfunction

  // Scoreboard state for the default instance
  bit          run_m = 0, done_pending = 0, prev_stall = 0, prev_req = 0, prev_xfer = 0, xfer_m;
  int          buffered = 0, fetch_exp = 0, exp_addr = 0, beats = 0, lasts = 0, stalls = 0;
  int          last_addr_seen = -1;
  logic [9:0]  prev_caddr;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (reset || abort) begin
      run_m = 0; buffered = 0; prev_stall = 0; prev_req = 0; prev_xfer = 0; done_pending = 0;
    end else begin
      if (done_pending) begin
        chk("done_complete", flatten_complete, 1);
        chk("done_out_valid", out_valid, 0);
        done_pending = 0;
      end
      if (!run_m) begin
        if (start) begin
          run_m = 1; buffered = 0; fetch_exp = 0; exp_addr = 0; beats = 0; lasts = 0;
          stalls = 0; last_addr_seen = -1; prev_stall = 0; prev_req = 0; prev_xfer = 0;
        end
      end else begin
        chk("valid_vs_fill", out_valid, (buffered > 0));
        if (buffered == 2) chk("no_req_both_full", request_chunk, 0);
        if (prev_xfer) chk("req_drop_after_xfer", request_chunk, 0);
        if (prev_req && !prev_xfer && request_chunk) chk("chunk_addr_stable", chunk_addr, prev_caddr);
        if (prev_stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_addr", out_addr, prev_addr);
          chk("hold_data", out_data, prev_data);
        end
        xfer_m = request_chunk && chunk_valid;
        if (xfer_m) begin
          chk("chunk_addr", chunk_addr, (int'(tb_base) + fetch_exp) % 1024);
          fetch_exp++; buffered++;
        end
        if (out_valid && out_ready) begin
          chk("out_addr", out_addr, exp_addr);
          chk("out_data", out_data, beat_model(exp_addr));
          chk("out_last", out_last, (exp_addr == 252));
          if (exp_addr == 0)   chk("pin_first_beat", out_data, 32'h03020100);
          if (exp_addr == 252) chk("pin_last_beat", out_data, 32'hFFFEFDFC);
          if (out_last) begin lasts++; last_addr_seen = int'(out_addr); end
          beats++; exp_addr += 4;
          if (exp_addr % 16 == 0) buffered--;
          if (exp_addr == 256) begin run_m = 0; done_pending = 1; end
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) stalls++;
        prev_req = request_chunk; prev_xfer = xfer_m; prev_caddr = chunk_addr;
        prev_addr = out_addr; prev_data = out_data;
      end
    end
  end

  // ---------------- 3x3x8, 8-element chunks, single lane ----------------
  logic        b_start = 1'b0, b_req, b_ov, b_last, b_busy, b_complete;
  logic [9:0]  b_caddr;
  logic [63:0] b_chunk;
  logic [7:0]  b_data;
  logic [6:0]  b_addr;
  bit          b_run = 0;
  int          b_exp = 0, b_beats = 0, b_chunks = 0, b_lasts = 0, b_last_addr = -1;

  flatten_stream #(
    .INPUT_HEIGHT(3), .INPUT_WIDTH(3), .INPUT_CHANNELS(8), .ELEM_BITS(8),
    .CHUNK_ELEMS(8), .OUT_LANES(1), .ADDR_W(10)
  ) dut_b (
    .clk(clk), .reset(reset), .start_flatten(b_start), .flatten_abort(1'b0),
    .base_chunk_addr(10'd0), .request_chunk(b_req), .chunk_addr(b_caddr),
    .input_chunk(b_chunk), .chunk_valid(b_req), .out_valid(b_ov), .out_ready(1'b1),
    .out_data(b_data), .out_addr(b_addr), .out_last(b_last), .busy(b_busy),
    .flatten_complete(b_complete)
  );

  always_comb begin
    b_chunk = '0;
    for (int i = 0; i < 8; i++) b_chunk[i*8 +: 8] = 8'(int'(b_caddr) * 8 + i);
  end

  always @(negedge clk) begin
    if (reset) begin
      b_run = 0;
    end else if (!b_run) begin
      if (b_start) begin
        b_run = 1; b_exp = 0; b_beats = 0; b_chunks = 0; b_lasts = 0; b_last_addr = -1;
      end
    end else begin
      if (b_req) begin
        chk("b_chunk_addr", b_caddr, b_chunks);
        b_chunks++;
      end
      if (b_ov) begin
        chk("b_out_addr", b_addr, b_exp);
        chk("b_out_data", b_data, b_exp % 256);
        chk("b_out_last", b_last, (b_exp == 71));
        if (b_last) begin b_lasts++; b_last_addr = int'(b_addr); end
        b_beats++; b_exp++;
        if (b_exp == 72) b_run = 0;
      end
    end
  end

  // ---------------- sequencing ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [9:0] b);
    tb_base = b; base_in = b; start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("start_latency_req", request_chunk, 1);
    chk("start_latency_addr", chunk_addr, b);
  endtask

  // Counts the start cycle as cycle 0 and returns the cycle in which DONE is observed.
  task automatic wait_complete(input int max, input bit rnd, output int cyc);
    cyc = 1;
    while (!flatten_complete && cyc < max) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    out_ready = 1'b1;
    chk("complete_reached", flatten_complete, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_request", request_chunk, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_complete", flatten_complete, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_chunk_addr", chunk_addr, 0);
    step();
    reset = 1'b0;
    step();

    // 1: zero-latency memory, consumer always ready
    mem_lat = 0; out_ready = 1'b1;
    run_start(10'h000);
    wait_complete(200, 0, cyc);
    chk("t1_cycles", cyc, 66);
    chk("t1_beats", beats, 64);
    chk("t1_lasts", lasts, 1);
    chk("t1_last_addr", last_addr_seen, 252);

    // 2: five-cycle memory latency, base near the top of the address space
    mem_lat = 5;
    run_start(10'h3F0);
    wait_complete(2000, 0, cyc);
    chk("t2_beats", beats, 64);
    chk("t2_chunks", fetch_exp, 16);

    // 3: random backpressure
    mem_lat = 1;
    run_start(10'h000);
    wait_complete(3000, 1, cyc);
    chk("t3_beats", beats, 64);
    chk("t3_stalled", (stalls > 0), 1);

    // 4: abort with a chunk arriving in the same cycle, then a clean restart
    mem_lat = 2;
    run_start(10'h000);
    cyc = 0;
    while (!(beats >= 20 && request_chunk && !chunk_valid) && cyc < 500) begin
      step(); cyc++;
    end
    chk("t4_abort_point", (beats >= 20 && request_chunk), 1);
    abort = 1'b1; cv_force = 1'b1; out_ready = 1'b0;
    step();
    abort = 1'b0;
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_request", request_chunk, 0);
    chk("t4_idle_valid", out_valid, 0);
    repeat (3) step();
    chk("t4_late_request", request_chunk, 0);
    chk("t4_late_valid", out_valid, 0);
    chk("t4_late_complete", flatten_complete, 0);
    cv_force = 1'b0; out_ready = 1'b1; mem_lat = 0;
    run_start(10'h000);
    wait_complete(200, 0, cyc);
    chk("t4_restart_beats", beats, 64);
    chk("t4_restart_lasts", lasts, 1);

    // 5: start ignored while running; restart from DONE with a new base
    run_start(10'h010);
    cyc = 0;
    while (beats < 10 && cyc < 200) begin step(); cyc++; end
    base_in = 10'h155; start = 1'b1;
    step();
    start = 1'b0; base_in = tb_base;
    chk("t5_still_busy", busy, 1);
    wait_complete(200, 0, cyc);
    chk("t5_beats", beats, 64);
    repeat (2) step();
    chk("t5_done_hold", flatten_complete, 1);
    run_start(10'h200);
    wait_complete(200, 0, cyc);
    chk("t5_rerun_beats", beats, 64);
    chk("t5_rerun_last_addr", last_addr_seen, 252);

    // 6: 3x3x8 tensor, 8-element chunks, one lane per beat
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    cyc = 1;
    while (!b_complete && cyc < 500) begin step(); cyc++; end
    chk("t6_complete", b_complete, 1);
    chk("t6_cycles", cyc, 74);
    chk("t6_beats", b_beats, 72);
    chk("t6_chunks", b_chunks, 9);
    chk("t6_lasts", b_lasts, 1);
    chk("t6_last_addr", b_last_addr, 71);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
